// File: rtl/branch_predictor.sv
// Decode-stage branch predictor with a PC-indexed table of 2-bit saturating counters,
// plus the execute-stage resolution checker that trains the table and counts outcomes.
module branch_predictor #(
    parameter  int BHT_ENTRIES = 64,
    localparam int INDEX_W     = $clog2(BHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCPlus4D,
    input  logic        StallD,
    input  logic        StallE,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic        PCSrcD,
    output logic [31:0] PCBranchD,
    output logic        MissPredictionE,
    output logic [31:0] BranchReturnE,
    output logic [31:0] BranchCount,
    output logic [31:0] MissCount
);

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_BR    = 2'd1,
        CLS_JAL   = 2'd2,
        CLS_JALR  = 2'd3
    } cls_t;

    logic [31:0]        pc_d;
    logic [INDEX_W-1:0] idx_d;
    cls_t               cls_d;
    logic [31:0]        imm_b;
    logic [31:0]        imm_j;
    logic [1:0]         ctr_d;
    logic               pred_taken_d;
    logic [31:0]        pred_target_d;

    logic [1:0]         bht_reg [BHT_ENTRIES];

    logic               valid_e_reg;
    cls_t               cls_e_reg;
    logic               pred_taken_e_reg;
    logic [INDEX_W-1:0] idx_e_reg;
    logic [31:0]        pc_plus4_e_reg;

    logic               miss_e;
    logic [31:0]        return_e;
    logic               retire_e;
    logic               train_en;
    logic [1:0]         ctr_e;
    logic [1:0]         ctr_next;
    logic [31:0]        branch_count_reg;
    logic [31:0]        miss_count_reg;

    // ---------------- Decode: classify, extract immediates, look up ----------------
    assign pc_d  = PCPlus4D - 32'd4;
    assign idx_d = pc_d[INDEX_W+1:2];
    assign imm_b = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    assign ctr_d = bht_reg[idx_d];

    always_comb begin
        case (InstrD[6:0])
            7'b1100011: cls_d = CLS_BR;
            7'b1101111: cls_d = CLS_JAL;
            7'b1100111: cls_d = CLS_JALR;
            default:    cls_d = CLS_OTHER;
        endcase
    end

    always_comb begin
        pred_taken_d  = 1'b0;
        pred_target_d = PCPlus4D;
        case (cls_d)
            CLS_BR: begin
                pred_taken_d  = ctr_d[1];
                pred_target_d = pc_d + imm_b;
            end
            CLS_JAL: begin
                pred_taken_d  = 1'b1;
                pred_target_d = pc_d + imm_j;
            end
            default: begin
                pred_taken_d  = 1'b0;
                pred_target_d = PCPlus4D;
            end
        endcase
    end

    // A pending E mispredict owns the fetch redirect; the D instruction is wrong-path.
    assign PCSrcD    = pred_taken_d & ~MissPredictionE;
    assign PCBranchD = pred_target_d;

    // ---------------- D -> E pipeline register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e_reg      <= 1'b0;
            cls_e_reg        <= CLS_OTHER;
            pred_taken_e_reg <= 1'b0;
            idx_e_reg        <= '0;
            pc_plus4_e_reg   <= 32'd0;
        end else if (StallE) begin
            valid_e_reg      <= valid_e_reg;
        end else if (MissPredictionE || StallD) begin
            valid_e_reg      <= 1'b0;
            cls_e_reg        <= CLS_OTHER;
            pred_taken_e_reg <= 1'b0;
        end else begin
            valid_e_reg      <= 1'b1;
            cls_e_reg        <= cls_d;
            pred_taken_e_reg <= pred_taken_d;
            idx_e_reg        <= idx_d;
            pc_plus4_e_reg   <= PCPlus4D;
        end
    end

    // ---------------- Execute: resolution ----------------
    always_comb begin
        miss_e   = 1'b0;
        return_e = 32'd0;
        if (valid_e_reg) begin
            case (cls_e_reg)
                CLS_BR: begin
                    miss_e   = (pred_taken_e_reg != BranchTakenE);
                    return_e = (miss_e && BranchTakenE) ? BranchTargetE : pc_plus4_e_reg;
                end
                CLS_JALR: begin
                    // Indirect targets are never predicted, so every JALR recovers in E.
                    miss_e   = 1'b1;
                    return_e = BranchTargetE;
                end
                default: begin
                    miss_e   = 1'b0;
                    return_e = pc_plus4_e_reg;
                end
            endcase
        end
    end

    assign MissPredictionE = miss_e;
    assign BranchReturnE   = return_e;

    // ---------------- Training and statistics, once per instruction leaving E ----------------
    assign retire_e = valid_e_reg & ~StallE;
    assign train_en = retire_e & (cls_e_reg == CLS_BR);
    assign ctr_e    = bht_reg[idx_e_reg];

    always_comb begin
        if (BranchTakenE)
            ctr_next = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'b01;
        else
            ctr_next = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'b01;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_reg[i] <= 2'b01;
        end else if (train_en) begin
            bht_reg[idx_e_reg] <= ctr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_reg <= 32'd0;
            miss_count_reg   <= 32'd0;
        end else if (retire_e) begin
            if (cls_e_reg == CLS_BR)
                branch_count_reg <= branch_count_reg + 32'd1;
            if (miss_e)
                miss_count_reg   <= miss_count_reg + 32'd1;
        end
    end

    assign BranchCount = branch_count_reg;
    assign MissCount   = miss_count_reg;

endmodule
